sap_core_param: RTL and testbench



---
 rtl/sap_core_param_if.sv | 25 ++
 rtl/sap_core_param.sv | 221 ++++++++++++++++++++++
 tb/tb_sap_core_param.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sap_core_param_if.sv
// Host-side bus of sap_core_param: program-load port, run control, output register and status.
interface sap_core_param_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic              start;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              halted;
  logic              flag_c;
  logic              flag_z;

  modport master (
    output start, prog_we, prog_addr, prog_data,
    input  out_data, out_valid, halted, flag_c, flag_z
  );

  modport slave (
    input  start, prog_we, prog_addr, prog_data,
    output out_data, out_valid, halted, flag_c, flag_z
  );
endinterface

// File: rtl/sap_core_param.sv
// Parametrised SAP accumulator core: A/B, ALU flags, PC, MAR, IR, RAM, output reg, T-state control.
// Define SAP_LOGIC_OPS_EN to enable the AND/OR/XOR opcodes (9/A/B); otherwise they execute as NOP.
module sap_core_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  sap_core_param_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned OP_W  = 4;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_LDA = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB = 4'h3;
  localparam logic [OP_W-1:0] OP_STA = 4'h4;
  localparam logic [OP_W-1:0] OP_LDI = 4'h5;
  localparam logic [OP_W-1:0] OP_JMP = 4'h6;
  localparam logic [OP_W-1:0] OP_JC  = 4'h7;
  localparam logic [OP_W-1:0] OP_JZ  = 4'h8;
`ifdef SAP_LOGIC_OPS_EN
  localparam logic [OP_W-1:0] OP_AND = 4'h9;
  localparam logic [OP_W-1:0] OP_OR  = 4'hA;
  localparam logic [OP_W-1:0] OP_XOR = 4'hB;
`endif
  localparam logic [OP_W-1:0] OP_OUT = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_HALT,
    S_F0,
    S_F1,
    S_E0,
    S_E1,
    S_E2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              halted_q, halted_d;
  logic              flag_c_q, flag_c_d;
  logic              flag_z_q, flag_z_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [OP_W-1:0]   opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] diff;
  logic              two_op;

  // Decode and datapath helpers; RAM read is asynchronous from MAR.
  always_comb begin
    opcode  = ir_q[DATA_W-1 -: OP_W];
    operand = ir_q[ADDR_W-1:0];
    rd_data = mem_q[mar_q];
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = a_q - b_q;
    two_op  = (opcode == OP_ADD) || (opcode == OP_SUB);
`ifdef SAP_LOGIC_OPS_EN
    two_op  = two_op || (opcode == OP_AND) || (opcode == OP_OR) || (opcode == OP_XOR);
`endif
  end

  // Next-state, datapath and RAM write control.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mar_d       = mar_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    flag_c_d    = flag_c_q;
    flag_z_d    = flag_z_q;
    mem_we      = 1'b0;
    mem_waddr   = mar_q;
    mem_wdata   = a_q;

    case (state_q)
      S_HALT: begin
        if (bus.start) state_d = S_F0;
      end
      S_F0: begin
        mar_d   = pc_q;
        state_d = S_F1;
      end
      S_F1: begin
        ir_d    = rd_data;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_E0;
      end
      S_E0: begin
        state_d = S_F0;
        if (two_op || (opcode == OP_LDA) || (opcode == OP_STA)) begin
          mar_d   = operand;
          state_d = S_E1;
        end else begin
          case (opcode)
            OP_NOP: ;
            OP_LDI: a_d = DATA_W'(operand);
            OP_JMP: pc_d = operand;
            OP_JC:  if (flag_c_q) pc_d = operand;
            OP_JZ:  if (flag_z_q) pc_d = operand;
            OP_OUT: begin
              out_d       = a_q;
              out_valid_d = 1'b1;
            end
            OP_HLT: state_d = S_HALT;
            default: ;
          endcase
        end
      end
      S_E1: begin
        state_d = S_F0;
        if (two_op) begin
          b_d     = rd_data;
          state_d = S_E2;
        end else if (opcode == OP_LDA) begin
          a_d = rd_data;
        end else if ((opcode == OP_STA) && !reset) begin
          mem_we = 1'b1;
        end
      end
      S_E2: begin
        state_d = S_F0;
        case (opcode)
          OP_ADD: begin
            {flag_c_d, a_d} = sum;
            flag_z_d        = (sum[DATA_W-1:0] == '0);
          end
          OP_SUB: begin
            a_d      = diff;
            flag_c_d = (a_q >= b_q);
            flag_z_d = (diff == '0);
          end
`ifdef SAP_LOGIC_OPS_EN
          OP_AND: begin
            a_d      = a_q & b_q;
            flag_c_d = 1'b0;
            flag_z_d = ((a_q & b_q) == '0);
          end
          OP_OR: begin
            a_d      = a_q | b_q;
            flag_c_d = 1'b0;
            flag_z_d = ((a_q | b_q) == '0);
          end
          OP_XOR: begin
            a_d      = a_q ^ b_q;
            flag_c_d = 1'b0;
            flag_z_d = ((a_q ^ b_q) == '0);
          end
`endif
          default: ;
        endcase
      end
      default: state_d = S_HALT;
    endcase

    // Host load wins; it is only accepted while halted or held in reset.
    if (bus.prog_we && ((state_q == S_HALT) || reset)) begin
      mem_we    = 1'b1;
      mem_waddr = bus.prog_addr;
      mem_wdata = bus.prog_data;
    end

    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_HALT;
      pc_q        <= '0;
      mar_q       <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b1;
      flag_c_q    <= 1'b0;
      flag_z_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mar_q       <= mar_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
      flag_c_q    <= flag_c_d;
      flag_z_q    <= flag_z_d;
    end
  end

  // Program RAM keeps its contents through reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign bus.out_data  = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.halted    = halted_q;
  assign bus.flag_c    = flag_c_q;
  assign bus.flag_z    = flag_z_q;
endmodule

// File: tb/tb_sap_core_param.sv
// Bench for sap_core_param: directed program table, hand sequences and random programs vs an ISA model.
module tb_sap_core_param;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int RUN_BUDGET = 500;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sap_core_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  sap_core_param #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;

  typedef logic [15:0][7:0] image_t;
  typedef struct {
    string      name;
    image_t     mem;
    logic [7:0] exp_out;
    int         exp_pulses;
    int         exp_cycles;
    logic       exp_c;
    logic       exp_z;
  } vec_t;

  int         d_cycles;
  logic [7:0] d_outs[$];

  // Instruction-level reference model state
  logic [7:0] m_mem[16];
  logic [3:0] m_pc;
  logic [7:0] m_a, m_out;
  logic       m_c, m_z;
  int         m_cycles;
  logic [7:0] m_outs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; bus.start = 1'b0; bus.prog_we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic write_word(input logic [3:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus.prog_we = 1'b1; bus.prog_addr = addr; bus.prog_data = data;
    @(negedge clk);
    bus.prog_we = 1'b0;
  endtask

  task automatic load(input image_t img);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.prog_we = 1'b1; bus.prog_addr = 4'(i); bus.prog_data = img[i];
    end
    @(negedge clk);
    bus.prog_we = 1'b0;
  endtask

  // Pulse start, then count edges until halted; noise hammers start/prog_we mid-run.
  task automatic run(input bit noise, input bit pre_we, input logic [3:0] pre_addr, input logic [7:0] pre_data);
    bit done;
    @(negedge clk);
    bus.start = 1'b1; bus.prog_we = pre_we; bus.prog_addr = pre_addr; bus.prog_data = pre_data;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.prog_we = 1'b0;
    d_cycles = 0; d_outs.delete(); done = 1'b0;
    while (!done) begin
      @(posedge clk); #1;
      d_cycles++;
      if (noise && d_cycles >= 2 && d_cycles <= 5) begin
        bus.start = 1'b1; bus.prog_we = 1'b1; bus.prog_addr = 4'hD; bus.prog_data = 8'h55;
      end else begin
        bus.start = 1'b0; bus.prog_we = 1'b0;
      end
      if (bus.out_valid) d_outs.push_back(bus.out_data);
      if (bus.halted) done = 1'b1;
      else if (d_cycles >= RUN_BUDGET) begin
        checks++; errors++;
        $display("FAIL run_timeout: still running after %0d cycles", d_cycles);
        done = 1'b1;
      end
    end
    bus.start = 1'b0; bus.prog_we = 1'b0;
  endtask

  task automatic check_run(input string nm, input int cyc, input int pulses, input logic [7:0] outv,
                           input logic c, input logic z);
    check({nm, ".cycles"}, d_cycles, cyc);
    check({nm, ".pulses"}, d_outs.size(), pulses);
    check({nm, ".out_data"}, bus.out_data, outv);
    if (d_outs.size() > 0) check({nm, ".pulse_value"}, d_outs[d_outs.size()-1], outv);
    check({nm, ".flag_c"}, bus.flag_c, c);
    check({nm, ".flag_z"}, bus.flag_z, z);
    check({nm, ".halted"}, bus.halted, 1);
  endtask

  task automatic model_reset();
    m_pc = '0; m_a = '0; m_out = '0; m_c = 1'b0; m_z = 1'b0;
  endtask

  task automatic model_load(input image_t img);
    for (int i = 0; i < 16; i++) m_mem[i] = img[i];
  endtask

  // Executes whole instructions; ok=1 once HLT is reached within the step limit.
  task automatic model_run(output bit ok);
    logic [7:0] w, opnd;
    logic [3:0] op, arg;
    logic [8:0] s;
    m_cycles = 0; m_outs.delete(); ok = 1'b0;
    for (int step = 0; step < 60 && !ok; step++) begin
      w = m_mem[m_pc]; op = w[7:4]; arg = w[3:0];
      opnd = m_mem[arg];
      m_pc = m_pc + 4'd1;
      case (op)
        4'h1: begin m_a = opnd; m_cycles += 4; end
        4'h2: begin s = {1'b0, m_a} + {1'b0, opnd}; m_a = s[7:0]; m_c = s[8]; m_z = (m_a == 0); m_cycles += 5; end
        4'h3: begin m_c = (m_a >= opnd); m_a = m_a - opnd; m_z = (m_a == 0); m_cycles += 5; end
        4'h4: begin m_mem[arg] = m_a; m_cycles += 4; end
        4'h5: begin m_a = {4'h0, arg}; m_cycles += 3; end
        4'h6: begin m_pc = arg; m_cycles += 3; end
        4'h7: begin if (m_c) m_pc = arg; m_cycles += 3; end
        4'h8: begin if (m_z) m_pc = arg; m_cycles += 3; end
`ifdef SAP_LOGIC_OPS_EN
        4'h9: begin m_a = m_a & opnd; m_c = 1'b0; m_z = (m_a == 0); m_cycles += 5; end
        4'hA: begin m_a = m_a | opnd; m_c = 1'b0; m_z = (m_a == 0); m_cycles += 5; end
        4'hB: begin m_a = m_a ^ opnd; m_c = 1'b0; m_z = (m_a == 0); m_cycles += 5; end
`endif
        4'hE: begin m_out = m_a; m_outs.push_back(m_a); m_cycles += 3; end
        4'hF: begin m_cycles += 3; ok = 1'b1; end
        default: m_cycles += 3;
      endcase
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   vecs[$];
    vec_t   v;
    image_t img;
    bit     ok;

    bus.start = 1'b0; bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.halted", bus.halted, 1);
    check("reset.out_valid", bus.out_valid, 0);
    check("reset.out_data", bus.out_data, 0);
    check("reset.flag_c", bus.flag_c, 0);
    check("reset.flag_z", bus.flag_z, 0);
    reset = 1'b0;

    // Directed program table
    v.name = "basic"; v.mem = '0;
    v.mem[0] = 8'h19; v.mem[1] = 8'h2A; v.mem[2] = 8'hE0; v.mem[3] = 8'hF0; v.mem[9] = 8'h10; v.mem[10] = 8'h14;
    v.exp_out = 8'h24; v.exp_pulses = 1; v.exp_cycles = 15; v.exp_c = 0; v.exp_z = 0; vecs.push_back(v);

    v.name = "carry_zero"; v.mem = '0;
    v.mem[0] = 8'h1E; v.mem[1] = 8'h2F; v.mem[2] = 8'h85; v.mem[3] = 8'hF0; v.mem[4] = 8'hF0;
    v.mem[5] = 8'hE0; v.mem[6] = 8'hF0; v.mem[14] = 8'hFF; v.mem[15] = 8'h01;
    v.exp_out = 8'h00; v.exp_pulses = 1; v.exp_cycles = 18; v.exp_c = 1; v.exp_z = 1; vecs.push_back(v);

    v.name = "borrow"; v.mem = '0;
    v.mem[0] = 8'h53; v.mem[1] = 8'h3E; v.mem[2] = 8'hE0; v.mem[3] = 8'hF0; v.mem[14] = 8'h05;
    v.exp_out = 8'hFE; v.exp_pulses = 1; v.exp_cycles = 14; v.exp_c = 0; v.exp_z = 0; vecs.push_back(v);

    v.name = "sub_equal"; v.mem = '0;
    v.mem[0] = 8'h53; v.mem[1] = 8'h3F; v.mem[2] = 8'hE0; v.mem[3] = 8'hF0; v.mem[15] = 8'h03;
    v.exp_out = 8'h00; v.exp_pulses = 1; v.exp_cycles = 14; v.exp_c = 1; v.exp_z = 1; vecs.push_back(v);

    v.name = "sta_lda"; v.mem = '0;
    v.mem[0] = 8'h57; v.mem[1] = 8'h4C; v.mem[2] = 8'h50; v.mem[3] = 8'h1C; v.mem[4] = 8'hE0; v.mem[5] = 8'hF0;
    v.exp_out = 8'h07; v.exp_pulses = 1; v.exp_cycles = 20; v.exp_c = 0; v.exp_z = 0; vecs.push_back(v);

    v.name = "pc_wrap"; v.mem = '0;
    v.mem[0] = 8'h83; v.mem[1] = 8'h3E; v.mem[2] = 8'h6F; v.mem[3] = 8'hE0; v.mem[4] = 8'hF0;
    v.exp_out = 8'h00; v.exp_pulses = 1; v.exp_cycles = 23; v.exp_c = 1; v.exp_z = 1; vecs.push_back(v);

    v.name = "logic_and"; v.mem = '0;
    v.mem[0] = 8'h1D; v.mem[1] = 8'h2D; v.mem[2] = 8'h1E; v.mem[3] = 8'h9F; v.mem[4] = 8'hE0; v.mem[5] = 8'hF0;
    v.mem[13] = 8'hFF; v.mem[14] = 8'hF0; v.mem[15] = 8'h3C;
`ifdef SAP_LOGIC_OPS_EN
    v.exp_out = 8'h30; v.exp_pulses = 1; v.exp_cycles = 24; v.exp_c = 0; v.exp_z = 0;
`else
    v.exp_out = 8'hF0; v.exp_pulses = 1; v.exp_cycles = 22; v.exp_c = 1; v.exp_z = 0;
`endif
    vecs.push_back(v);

    v.name = "nop_cd"; v.mem = '0;
    v.mem[0] = 8'h5A; v.mem[1] = 8'hC0; v.mem[2] = 8'hD3; v.mem[3] = 8'hE0; v.mem[4] = 8'hF0;
    v.exp_out = 8'h0A; v.exp_pulses = 1; v.exp_cycles = 15; v.exp_c = 0; v.exp_z = 0; vecs.push_back(v);

    foreach (vecs[i]) begin
      do_reset();
      load(vecs[i].mem);
      run(1'b0, 1'b0, '0, '0);
      check_run(vecs[i].name, vecs[i].exp_cycles, vecs[i].exp_pulses, vecs[i].exp_out, vecs[i].exp_c, vecs[i].exp_z);
    end

    // Reset in E1 of ADD, then confirm A cleared and RAM retained
    do_reset();
    load(vecs[0].mem);
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid_add.running", bus.halted, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_add.halted", bus.halted, 1);
    check("mid_add.out_valid", bus.out_valid, 0);
    check("mid_add.flag_c", bus.flag_c, 0);
    write_word(4'h0, 8'hE0);
    write_word(4'h1, 8'hF0);
    run(1'b0, 1'b0, '0, '0);
    check_run("mid_add.a_cleared", 6, 1, 8'h00, 0, 0);
    write_word(4'h2, 8'h19);
    write_word(4'h3, 8'hE0);
    write_word(4'h4, 8'hF0);
    run(1'b0, 1'b0, '0, '0);
    check_run("mid_add.ram_kept", 10, 1, 8'h10, 0, 0);

    // start and prog_we while running are ignored
    do_reset();
    img = '0;
    img[4] = 8'h1D; img[5] = 8'hE0; img[6] = 8'hF0; img[13] = 8'h11;
    load(img);
    run(1'b1, 1'b0, '0, '0);
    check_run("run_guard", 22, 1, 8'h11, 0, 0);
    write_word(4'h7, 8'h1D);
    write_word(4'h8, 8'hE0);
    write_word(4'h9, 8'hF0);
    run(1'b0, 1'b0, '0, '0);
    check_run("run_guard.ram", 10, 1, 8'h11, 0, 0);

    // HLT then start resumes after the HLT
    do_reset();
    img = '0;
    img[0] = 8'hF0; img[1] = 8'h55; img[2] = 8'hE0; img[3] = 8'hF0;
    load(img);
    run(1'b0, 1'b0, '0, '0);
    check_run("resume.first", 3, 0, 8'h00, 0, 0);
    run(1'b0, 1'b0, '0, '0);
    check_run("resume.second", 9, 1, 8'h05, 0, 0);

    // Write in the same cycle as start is seen by the first fetch
    do_reset();
    img = '0;
    img[0] = 8'hF0; img[1] = 8'hE0; img[2] = 8'hF0;
    load(img);
    run(1'b0, 1'b1, 4'h0, 8'h5A);
    check_run("start_with_we", 9, 1, 8'h0A, 0, 0);

    // Random programs against the instruction-level model
    for (int t = 0; t < 25; t++) begin
      ok = 1'b0;
      for (int tr = 0; tr < 20 && !ok; tr++) begin
        for (int a = 0; a < 16; a++) begin
          int r;
          r = int'($urandom_range(0, 19));
          if (r > 15) r = 15;
          img[a] = {4'(r), 4'($urandom)};
        end
        model_reset(); model_load(img); model_run(ok);
      end
      if (!ok) begin
        img = '0; img[0] = 8'hF0;
        model_reset(); model_load(img); model_run(ok);
      end
      do_reset();
      load(img);
      run(1'b0, 1'b0, '0, '0);
      check_run("random", m_cycles, m_outs.size(), m_out, m_c, m_z);
      for (int k = 0; k < m_outs.size() && k < d_outs.size(); k++)
        check("random.out_seq", d_outs[k], m_outs[k]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
